// File: rtl/array_copy_pkg.sv
// array_copy_pkg: shared FSM state type and default sizing for the array copier
package array_copy_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/array_copy_buf.sv
// array_copy_buf: 2-entry in-order buffer of read data tagged with its element index
module array_copy_buf
    import array_copy_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AW-1:0]    idx_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic [AW-1:0]    head_idx_o
);

    logic [WIDTH-1:0] data_q [2];
    logic [AW-1:0]    idx_q  [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       cnt_q;

    assign full_o      = cnt_q == 2'd2;
    assign empty_o     = cnt_q == 2'd0;
    assign head_data_o = data_q[rd_ptr_q];
    assign head_idx_o  = idx_q[rd_ptr_q];

    // Entry storage and pointers; push and pop may coincide in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            idx_q[0]  <= '0;
            idx_q[1]  <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= data_i;
                idx_q[wr_ptr_q]  <= idx_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i)
                rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

endmodule

// File: rtl/array_copy_seq.sv
// array_copy_seq: copies min(len, DEPTH) elements from a 1-cycle-latency source to a ready/valid sink
module array_copy_seq
    import array_copy_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic             src_rd_en,
    output logic [AW-1:0]    src_addr,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_we,
    output logic [AW-1:0]    dst_addr,
    output logic [WIDTH-1:0] dst_data,
    input  logic             dst_ready
);

    localparam int LW = AW + 1;

    state_t         state_q;
    logic [LW-1:0]  eff_len_q;
    logic [LW-1:0]  eff_len_d;
    logic [LW-1:0]  rd_idx_q;
    logic [LW-1:0]  wr_idx_q;
    logic [AW-1:0]  rd_tag_q;
    logic           infl_q;
    logic           buf_full;
    logic           buf_empty;
    logic [WIDTH-1:0] head_data;
    logic [AW-1:0]  head_idx;
    logic [1:0]     occ;
    logic           accept;
    logic           rd_en;
    logic           last_wr;

    assign eff_len_d = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    assign occ       = {buf_full, ~buf_empty & ~buf_full};
    assign accept    = dst_we & dst_ready;
    // A new read is allowed only if the buffer can still absorb it after this cycle's pop
    assign rd_en     = (state_q == RUN) && (rd_idx_q < eff_len_q) &&
                       (({1'b0, occ} + {2'b0, infl_q}) <= ({2'b0, accept} + 3'd1));
    assign last_wr   = accept && ((wr_idx_q + 1'b1) == eff_len_q);

    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign src_rd_en = rd_en;
    assign src_addr  = rd_en ? rd_idx_q[AW-1:0] : '0;
    assign dst_we    = ~buf_empty;
    assign dst_addr  = dst_we ? head_idx : '0;
    assign dst_data  = dst_we ? head_data : '0;

    array_copy_buf #(
        .WIDTH(WIDTH),
        .AW   (AW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (infl_q),
        .pop_i      (accept),
        .data_i     (src_data),
        .idx_i      (rd_tag_q),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .head_data_o(head_data),
        .head_idx_o (head_idx)
    );

    // Control FSM with read/write indices and the one-deep read-in-flight tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            eff_len_q <= '0;
            rd_idx_q  <= '0;
            wr_idx_q  <= '0;
            rd_tag_q  <= '0;
            infl_q    <= 1'b0;
        end else begin
            infl_q   <= rd_en;
            rd_tag_q <= rd_idx_q[AW-1:0];
            if (rd_en)
                rd_idx_q <= rd_idx_q + 1'b1;
            if (accept)
                wr_idx_q <= wr_idx_q + 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    eff_len_q <= eff_len_d;
                    rd_idx_q  <= '0;
                    wr_idx_q  <= '0;
                    state_q   <= (eff_len_d == '0) ? DONE : RUN;
                end
                RUN:     if (last_wr) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_array_copy_seq.sv
// tb_array_copy_seq: directed checks of cycle timing, ordering, backpressure and reset of array_copy_seq
module tb_array_copy_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic        src_rd_en;
    logic [3:0]  src_addr;
    logic [31:0] src_data = 32'd0;
    logic        dst_we;
    logic [3:0]  dst_addr;
    logic [31:0] dst_data;
    logic        dst_ready;

    int total = 0;
    int bad   = 0;

    array_copy_seq #(.WIDTH(32), .DEPTH(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .src_rd_en(src_rd_en),
        .src_addr (src_addr),
        .src_data (src_data),
        .dst_we   (dst_we),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_ready(dst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [3:0] a);
        return 32'hC0DE_0000 + 32'(a) * 32'h111;
    endfunction

    // Source memory with one cycle of read latency; garbage when not read
    always @(posedge clk) src_data <= src_rd_en ? dat(src_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: ready 1 plus a start pulse in cycle 3
    task automatic run(input int n, input int mode, input string tag,
                       input int e_rd, input int e_rf, input int e_rl,
                       input int e_wr, input int e_wf, input int e_done, input int e_busy);
        int rd_n = 0, rf = 0, rl = 0, wr_n = 0, wf = 0, wl = 0;
        int done_c = 0, busy_n = 0, max_out = 0;
        bit fin = 0, p_hold = 0;
        logic [3:0]  p_addr = '0;
        logic [31:0] p_data = '0;
        @(negedge clk);
        start = 1'b1;
        len   = 5'(n);
        @(posedge clk);
        for (int k = 1; k <= 60 && !fin; k++) begin
            #1;
            start = (mode == 2 && k == 3);
            if (mode == 2 && k == 3) len = 5'd2;
            dst_ready = (mode == 1) ? (k % 3 == 1) : 1'b1;
            @(negedge clk);
            if (done_c != 0) begin
                check({tag, ".idle"}, {busy, done, src_rd_en, dst_we}, 0);
                fin = 1;
            end else begin
                if (rd_n - wr_n > max_out) max_out = rd_n - wr_n;
                if (p_hold)
                    check({tag, ".hold"}, {dst_we, dst_addr, dst_data}, {1'b1, p_addr, p_data});
                if (busy) busy_n++;
                if (src_rd_en) begin
                    check({tag, ".raddr"}, src_addr, rd_n);
                    if (rf == 0) rf = k;
                    rl = k;
                    rd_n++;
                end
                if (dst_we && dst_ready) begin
                    check({tag, ".waddr"}, dst_addr, wr_n);
                    check({tag, ".wdata"}, dst_data, dat(wr_n[3:0]));
                    if (wf == 0) wf = k;
                    wl = k;
                    wr_n++;
                end
                p_hold = dst_we && !dst_ready;
                p_addr = dst_addr;
                p_data = dst_data;
                if (done) done_c = k;
            end
            @(posedge clk);
        end
        check({tag, ".nrd"}, rd_n, e_rd);
        check({tag, ".rfirst"}, rf, e_rf);
        check({tag, ".rlast"}, rl, e_rl);
        check({tag, ".nwr"}, wr_n, e_wr);
        check({tag, ".wfirst"}, wf, e_wf);
        check({tag, ".wlast"}, wl, (e_wr > 0) ? e_done - 1 : 0);
        check({tag, ".done"}, done_c, e_done);
        check({tag, ".busy"}, busy_n, e_busy);
        check({tag, ".outst"}, max_out <= 2, 1);
    endtask

    initial begin
        bit any;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        dst_ready = 1'b0;
        #1;
        check("rst.out", {busy, done, src_rd_en, src_addr, dst_we, dst_addr, dst_data}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run(4,  0, "len4",  4, 1, 4,  4, 3,  7,  7);
        run(0,  0, "len0",  0, 0, 0,  0, 0,  1,  1);
        run(15, 0, "len15", 10, 1, 10, 10, 3, 13, 13);
        run(6,  1, "tog",   6, 1, 13, 6, 4,  20, 20);
        run(5,  2, "restart", 5, 1, 5, 5, 3, 8,  8);

        // Fill the buffer under backpressure, then reset mid-copy
        @(negedge clk);
        start     = 1'b1;
        len       = 5'd6;
        dst_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid.full", {dst_we, dst_addr, dst_data, src_rd_en}, {1'b1, 4'd0, dat(4'd0), 1'b0});
        #2 rst = 1'b1;
        #1 check("mid.rst", {busy, done, src_rd_en, src_addr, dst_we, dst_addr, dst_data}, 0);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        dst_ready = 1'b1;
        any       = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any |= dst_we | src_rd_en | busy | done;
        end
        check("mid.quiet", any, 0);

        run(3, 0, "post", 3, 1, 3, 3, 3, 6, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/array_copy_seq.md
ARRAY_COPY_SEQ -- requirements
Module: array_copy_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, element width in bits.
REQ-002 SHALL have parameter DEPTH, default 10, array length; AW = max(1, clog2(DEPTH)) is a derived localparam.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to copy len elements, sampled only in IDLE.
REQ-006 SHALL have port len  input  AW+1  element count, sampled with start.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port src_rd_en  output  1  source read strobe.
REQ-010 SHALL have port src_addr  output  AW  source index.
REQ-011 SHALL have port src_data  input  WIDTH  source data, valid exactly one cycle after src_rd_en.
REQ-012 SHALL have port dst_we  output  1  destination write valid.
REQ-013 SHALL have port dst_addr  output  AW  destination index.
REQ-014 SHALL have port dst_data  output  WIDTH  destination data.
REQ-015 SHALL have port dst_ready  input  1  destination accepts; a write completes on dst_we & dst_ready.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE with start=1, latch eff_len = min(len, DEPTH), clear rd_idx and wr_idx, and go to RUN, or to DONE if eff_len=0.
REQ-018 SHALL ignore start in RUN and DONE.
REQ-019 SHALL assert src_rd_en with src_addr=rd_idx in RUN iff rd_idx<eff_len and (buffer occupancy + reads in flight − write accepted this cycle) ≤ 1; rd_idx then increments.
REQ-020 SHALL push src_data, tagged with its index, into a 2-entry in-order buffer in the cycle after each src_rd_en.
REQ-021 SHALL drive dst_we=1 whenever the buffer is non-empty, with dst_addr/dst_data taken from the head entry.
REQ-022 SHALL hold dst_we, dst_addr and dst_data stable while dst_ready=0; the head pops only on an accepted write.
REQ-023 SHALL write destination addresses 0..eff_len−1 strictly in order, each exactly once, with no drops or duplicates under any dst_ready pattern.
REQ-024 SHALL sustain one element per cycle while dst_ready=1.
REQ-025 SHALL go from RUN to DONE in the cycle after the write of index eff_len−1 is accepted.
REQ-026 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-027 SHALL, for eff_len=N≥1 with dst_ready constantly 1 and start sampled at edge 0, issue src_rd_en in cycles 1..N, dst_we in cycles 3..N+2, and done in cycle N+3.
REQ-028 SHALL, for eff_len=0, assert done in cycle 1 with no src_rd_en or dst_we.
REQ-029 SHALL never issue src_rd_en or dst_we outside RUN.

Reset
REQ-030 SHALL, on rst=1 at any time including mid-copy, asynchronously force IDLE, buffer empty, in-flight flag cleared, and rd_idx, wr_idx and eff_len zero.
REQ-031 SHALL drive all outputs to 0 during reset: busy, done, src_rd_en, src_addr, dst_we, dst_addr, dst_data.
REQ-032 SHALL discard any in-flight or buffered element on reset; it is never written.

Structure
REQ-033 SHALL define the FSM state enum and the default WIDTH/DEPTH constants in shared package array_copy_pkg.
REQ-034 SHALL implement the 2-entry buffer as sub-module array_copy_buf (push, pop, full, empty, head data and index, asynchronous active-high rst).

Verification
REQ-035 SHALL cover: DEPTH=10, len=4, dst_ready=1 -> reads in cycles 1-4, writes of addresses 0-3 in cycles 3-6 with matching data, done in cycle 7.
REQ-036 SHALL cover: len=0 -> done in cycle 1, no reads or writes, busy high for one cycle only.
REQ-037 SHALL cover: len=15 with DEPTH=10 -> exactly 10 writes, addresses 0-9, then done.
REQ-038 SHALL cover: len=6, dst_ready toggling 1,0,0,1,… -> outputs stable while ready is low, 6 in-order writes, never more than 2 elements outstanding.
REQ-039 SHALL cover: start pulsed again mid-copy -> ignored, and the original copy completes unchanged.
REQ-040 SHALL cover: rst asserted while 2 elements are buffered -> all outputs 0 immediately, no further writes, and a subsequent start with len=3 completes normally.
